mac_array_engine: RTL and testbench

- Parametrised multi-lane, precision-scalable MAC engine with batch accumulation and valid/ready streaming on input and output.
- LANES independent lanes; each multiplies one 8-bit activation by one 8-bit weight per beat in 2b/4b/8b sum-together mode and accumulates over batch_size beats.
- Sits between the activation/weight buffers and the output writeback/requantisation stage.
- Generation after the single-lane fixed-width engine; adds per-lane accumulation, input back-pressure and a result register.

---
 rtl/mac_array_engine_if.sv | 24 ++
 rtl/mac_array_engine.sv | 197 +++++++++++++++++++
 tb/tb_mac_array_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_engine_if.sv
// Streaming bus for mac_array_engine: the activation/weight beat input and the result output.
// The engine connects through the slave modport and its feeder through the master modport.
interface mac_array_engine_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic [8*LANES-1:0]       activations;
    logic [8*LANES-1:0]       weights;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W*LANES-1:0]   out_data;

    modport slave (
        input  in_valid, activations, weights, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, activations, weights, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mac_array_engine.sv
// Multi-lane precision-scalable MAC engine (2b/4b/8b sum-together) with batch accumulation.
// Optional macro MAC_ARRAY_SATURATE_EN: signed saturating accumulation plus a sticky per-lane ovf output.
module mac_array_engine #(
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [7:0]  batch_size,
    input  logic [1:0]  mode,
    input  logic        sx,
    input  logic        sy,
    output logic        busy,
`ifdef MAC_ARRAY_SATURATE_EN
    output logic [LANES-1:0] ovf,
`endif
    mac_array_engine_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [7:0]                     bsize_q, bsize_d;
    logic [1:0]                     mode_q, mode_d;
    logic                           sx_q, sx_d;
    logic                           sy_q, sy_d;
    logic [8*LANES-1:0]             opx_q, opx_d;
    logic [8*LANES-1:0]             opy_q, opy_d;
    logic [LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
    logic [LANES-1:0][ACC_W-1:0]    res_q, res_d;
    logic                           out_valid_q, out_valid_d;
`ifdef MAC_ARRAY_SATURATE_EN
    logic [LANES-1:0]               ovf_q, ovf_d;
`endif

    logic in_ready;
    logic accept;

    // Sum of sub-field products for one lane; sub-fields sign-extended per xs/ys, mode 3 behaves as 8b.
    function automatic logic signed [17:0] lane_sum(input logic [7:0] x, input logic [7:0] y,
                                                    input logic [1:0] m, input logic xs,
                                                    input logic ys);
        logic signed [17:0] xe, ye, s;
        s = '0;
        case (m)
            2'd0: begin
                for (int k = 0; k < 4; k++) begin
                    xe = {{16{xs & x[2*k+1]}}, x[2*k +: 2]};
                    ye = {{16{ys & y[2*k+1]}}, y[2*k +: 2]};
                    s  = s + xe * ye;
                end
            end
            2'd1: begin
                for (int k = 0; k < 2; k++) begin
                    xe = {{14{xs & x[4*k+3]}}, x[4*k +: 4]};
                    ye = {{14{ys & y[4*k+3]}}, y[4*k +: 4]};
                    s  = s + xe * ye;
                end
            end
            default: begin
                xe = {{10{xs & x[7]}}, x};
                ye = {{10{ys & y[7]}}, y};
                s  = xe * ye;
            end
        endcase
        return s;
    endfunction

    assign in_ready        = (state_q == S_RUN) && (cnt_q < bsize_q);
    assign accept          = bus.in_valid && in_ready;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = res_q;
    assign busy            = (state_q != S_IDLE);
`ifdef MAC_ARRAY_SATURATE_EN
    assign ovf             = ovf_q;
`endif

    always_comb begin
        logic signed [17:0]   ls;
        logic [ACC_W-1:0]     ext;
        logic [ACC_W:0]       wide;

        // NOTE: every *_d gets a default before any branch so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        bsize_d     = bsize_q;
        mode_d      = mode_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        opx_d       = '0;
        opy_d       = '0;
        res_d       = res_q;
        out_valid_d = out_valid_q;
`ifdef MAC_ARRAY_SATURATE_EN
        ovf_d       = ovf_q;
`endif
        ls   = '0;
        ext  = '0;
        wide = '0;

        // The operand register holds zero on idle cycles, so this stage adds 0 then.
        for (int i = 0; i < LANES; i++) begin
            ls   = lane_sum(opx_q[8*i +: 8], opy_q[8*i +: 8], mode_q, sx_q, sy_q);
            ext  = ACC_W'(ls);
`ifdef MAC_ARRAY_SATURATE_EN
            wide = {acc_q[i][ACC_W-1], acc_q[i]} + {ext[ACC_W-1], ext};
            if (wide[ACC_W] != wide[ACC_W-1]) begin
                acc_d[i] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                ovf_d[i] = 1'b1;
            end else begin
                acc_d[i] = wide[ACC_W-1:0];
            end
`else
            wide     = {1'b0, acc_q[i]} + {1'b0, ext};
            acc_d[i] = wide[ACC_W-1:0];
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bsize_d = batch_size;
                    mode_d  = mode;
                    sx_d    = sx;
                    sy_d    = sy;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef MAC_ARRAY_SATURATE_EN
                    ovf_d   = '0;
`endif
                    state_d = (batch_size == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    opx_d = bus.activations;
                    opy_d = bus.weights;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == bsize_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle loads the result register; afterwards it holds until handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    res_d       = acc_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bsize_q     <= '0;
            mode_q      <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            opx_q       <= '0;
            opy_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MAC_ARRAY_SATURATE_EN
            ovf_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bsize_q     <= bsize_d;
            mode_q      <= mode_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
`ifdef MAC_ARRAY_SATURATE_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine: a 24-bit instance for the main cases and a 16-bit
// instance fed in lockstep for the wrap/saturate case.
module tb_mac_array_engine;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [7:0]  batch_size;
    logic [1:0]  mode;
    logic        sx;
    logic        sy;
    logic        busy;
    logic        busy16;
    int          checks;
    int          errors;
`ifdef MAC_ARRAY_SATURATE_EN
    logic [3:0]  ovf;
    logic [3:0]  ovf16;
`endif

    mac_array_engine_if #(.LANES(4), .ACC_W(24)) bus ();
    mac_array_engine_if #(.LANES(4), .ACC_W(16)) bus16 ();

    assign bus16.in_valid    = bus.in_valid;
    assign bus16.activations = bus.activations;
    assign bus16.weights     = bus.weights;
    assign bus16.out_ready   = bus.out_ready;

    mac_array_engine #(.LANES(4), .ACC_W(24)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .batch_size (batch_size),
        .mode       (mode),
        .sx         (sx),
        .sy         (sy),
        .busy       (busy),
`ifdef MAC_ARRAY_SATURATE_EN
        .ovf        (ovf),
`endif
        .bus        (bus.slave)
    );

    mac_array_engine #(.LANES(4), .ACC_W(16)) dut16 (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .batch_size (batch_size),
        .mode       (mode),
        .sx         (sx),
        .sy         (sy),
        .busy       (busy16),
`ifdef MAC_ARRAY_SATURATE_EN
        .ovf        (ovf16),
`endif
        .bus        (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] bs, input logic [1:0] m, input logic sxv,
                            input logic syv);
        batch_size = bs;
        mode       = m;
        sx         = sxv;
        sy         = syv;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Feeds n beats (optionally with in_valid toggling), then leaves junk on the bus with in_valid high.
    task automatic run_beats(input string tag, input int n, input bit gaps,
                             input logic [31:0] x, input logic [31:0] y);
        int  got_n;
        int  cyc;
        bit  ph;
        got_n = 0;
        cyc   = 0;
        ph    = 1'b0;
        bus.activations = x;
        bus.weights     = y;
        while (got_n < n && cyc < 200) begin
            bus.in_valid = gaps ? ph : 1'b1;
            ph = !ph;
            if (gaps) check({tag, "_busy"}, busy, 1'b1);
            if (bus.in_valid && bus.in_ready) got_n++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check({tag, "_timeout"}, 128'(got_n), 128'(n));
        bus.in_valid    = 1'b1;
        bus.activations = 32'h5A5A_5A5A;
        bus.weights     = 32'hA5A5_A5A5;
    endtask

    // Called at the negedge after the last accepting edge N; out_valid must rise at edge N+2.
    task automatic wait_result(input string tag, input logic [95:0] exp);
        check({tag, "_inready_drop"}, bus.in_ready, 1'b0);
        check({tag, "_lat_n1"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat_n2"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_data"}, bus.out_data, exp);
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_hs_valid"}, bus.out_valid, 1'b0);
        check({tag, "_hs_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [95:0] held;
        checks          = 0;
        errors          = 0;
        nrst            = 1'b0;
        start           = 1'b0;
        batch_size      = '0;
        mode            = '0;
        sx              = 1'b0;
        sy              = 1'b0;
        bus.in_valid    = 1'b0;
        bus.activations = '0;
        bus.weights     = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", bus.out_data, 96'h0);
        nrst = 1'b1;
        @(negedge clk);

        // 8b unsigned, 3 beats of 255*255.
        do_start(8'd3, 2'd2, 1'b0, 1'b0);
        check("t1_busy", busy, 1'b1);
        run_beats("t1", 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("t1", {4{24'h02FA03}});
        handshake("t1");

        // 4b signed: 1 + (-56) = -55.
        do_start(8'd1, 2'd1, 1'b1, 1'b1);
        run_beats("t2", 1, 1'b0, {4{8'h7F}}, {4{8'h8F}});
        wait_result("t2", {4{24'hFFFFC9}});
        handshake("t2");

        // 4b unsigned, same bytes: 15*15 + 7*8 = 281.
        do_start(8'd1, 2'd1, 1'b0, 1'b0);
        run_beats("t2u", 1, 1'b0, {4{8'h7F}}, {4{8'h8F}});
        wait_result("t2u", {4{24'h000119}});
        handshake("t2u");

        // Reserved mode behaves as 8b: 127*143 = 18161.
        do_start(8'd1, 2'd3, 1'b0, 1'b0);
        run_beats("t_m3", 1, 1'b0, {4{8'h7F}}, {4{8'h8F}});
        wait_result("t_m3", {4{24'h0046F1}});
        handshake("t_m3");

        // 2b mixed signedness: four (-1)*3 per beat, two beats.
        do_start(8'd2, 2'd0, 1'b1, 1'b0);
        run_beats("t3", 2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("t3", {4{24'hFFFFE8}});
        handshake("t3");

        // Distinct per-lane data: lane i = (i+1)*16 per beat, two beats.
        do_start(8'd2, 2'd2, 1'b0, 1'b0);
        run_beats("t5", 2, 1'b0, 32'h0403_0201, 32'h1010_1010);
        wait_result("t5", {24'd128, 24'd96, 24'd64, 24'd32});
        handshake("t5");

        // Gapped input, stalled output, ignored starts.
        do_start(8'd3, 2'd2, 1'b0, 1'b0);
        run_beats("t4", 3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("t4", {4{24'h02FA03}});
        held = {4{24'h02FA03}};
        for (int c = 0; c < 5; c++) begin
            start      = (c == 2);
            batch_size = 8'd7;
            @(negedge clk);
            start = 1'b0;
            check("t4_hold_valid", bus.out_valid, 1'b1);
            check("t4_hold_data", bus.out_data, held);
            check("t4_hold_busy", busy, 1'b1);
        end
        // start coincident with the output handshake must not launch a batch.
        start         = 1'b1;
        batch_size    = 8'd2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        bus.out_ready = 1'b0;
        check("t4_hs_valid", bus.out_valid, 1'b0);
        check("t4_hs_busy", busy, 1'b0);
        @(negedge clk);
        check("t4_idle_inready", bus.in_ready, 1'b0);

        // Zero-length batch.
        do_start(8'd0, 2'd2, 1'b0, 1'b0);
        check("t6_busy", busy, 1'b1);
        check("t6_valid_early", bus.out_valid, 1'b0);
        @(negedge clk);
        check("t6_valid", bus.out_valid, 1'b1);
        check("t6_data", bus.out_data, 96'h0);
        handshake("t6");

        // 8b signed (-128)*(-128) three times; 16-bit lanes wrap or saturate.
        do_start(8'd3, 2'd2, 1'b1, 1'b1);
        run_beats("t8", 3, 1'b0, {4{8'h80}}, {4{8'h80}});
        wait_result("t8", {4{24'h00C000}});
`ifdef MAC_ARRAY_SATURATE_EN
        check("t8_acc16", bus16.out_data, {4{16'h7FFF}});
        check("t8_ovf16", ovf16, 4'hF);
        check("t8_ovf24", ovf, 4'h0);
`else
        check("t8_acc16", bus16.out_data, {4{16'hC000}});
`endif
        check("t8_valid16", bus16.out_valid, 1'b1);
        handshake("t8");

        // Reset in the middle of a batch aborts it and zeroes the outputs.
        do_start(8'd3, 2'd2, 1'b0, 1'b0);
        bus.activations = 32'h0101_0101;
        bus.weights     = 32'h0101_0101;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid    = 1'b0;
        check("t7_pre_busy", busy, 1'b1);
        check("t7_pre_data", bus.out_data, {4{24'h00C000}});
        nrst = 1'b0;
        @(negedge clk);
        check("t7_in_ready", bus.in_ready, 1'b0);
        check("t7_out_valid", bus.out_valid, 1'b0);
        check("t7_busy", busy, 1'b0);
        check("t7_out_data", bus.out_data, 96'h0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_no_result", bus.out_valid, 1'b0);
        check("t7_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
